// File: rtl/xyolo_macc_pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xyolo_macc_pool_pkg : shared types and codes for the YOLO MAC/pool   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package xyolo_macc_pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;

  localparam int LEN_W_DEF    = 12;
  localparam int MP_W_DEF     = 3;
  localparam int DRAIN_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/xyolo_postproc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xyolo_postproc : shift, activation, saturation with output register  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module xyolo_postproc
  import xyolo_macc_pool_pkg::*;
#(
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16,
  parameter int SHIFT_W  = 5,
  parameter int LEAKY_SH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic [1:0]               act_mode,
  input  logic                     sat_en,
  output logic                     out_valid,
  output logic                     out_last,
  output logic signed [OUT_W-1:0]  out_data
);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] act_v;
  logic signed [OUT_W-1:0] res;

  always_comb begin
    shifted = acc >>> shift;
    act_v   = shifted;
    case (act_mode)
      ACT_RELU:  if (shifted < 0) act_v = '0;
      ACT_LEAKY: if (shifted < 0) act_v = shifted >>> LEAKY_SH;
      default:   act_v = shifted;
    endcase
    res = act_v[OUT_W-1:0];
    if (sat_en) begin
      if (act_v > MAX_V)      res = MAX_V[OUT_W-1:0];
      else if (act_v < MIN_V) res = MIN_V[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_last  <= in_valid & in_last;
      if (in_valid) out_data <= res;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xyolo_macc_pool.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xyolo_macc_pool : self-sequenced signed MAC, post-process, max-pool  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module xyolo_macc_pool
  import xyolo_macc_pool_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 2*DATA_W+8,
  parameter int OUT_W    = 16,
  parameter int LEN_W    = 12,
  parameter int SHIFT_W  = 5,
  parameter int MP_W     = 3,
  parameter int LEAKY_SH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [LEN_W-1:0]         acc_len,
  input  logic [LEN_W-1:0]         n_groups,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     bias_en,
  input  logic [1:0]               act_mode,
  input  logic                     sat_en,
  input  logic [MP_W-1:0]          mp_len,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] op_a,
  input  logic signed [DATA_W-1:0] op_b,
  input  logic signed [DATA_W-1:0] op_c,
  output logic                     in_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     done
);

  state_t               state;
  logic [1:0]           drain_cnt;
  logic [LEN_W-1:0]     cfg_len, cfg_ng, smp_cnt, grp_cnt;
  logic [SHIFT_W-1:0]   cfg_shift;
  logic                 cfg_bias, cfg_sat;
  logic [1:0]           cfg_act;
  logic [MP_W-1:0]      cfg_mp;

  logic accept, smp_last, grp_last;
  assign accept   = in_valid & in_ready;
  assign smp_last = (smp_cnt == cfg_len - LEN_W'(1));
  assign grp_last = (grp_cnt == cfg_ng - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
      smp_cnt   <= '0;
      grp_cnt   <= '0;
      cfg_len   <= '0;
      cfg_ng    <= '0;
      cfg_shift <= '0;
      cfg_bias  <= 1'b0;
      cfg_act   <= ACT_NONE;
      cfg_sat   <= 1'b0;
      cfg_mp    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            cfg_len   <= acc_len;
            cfg_ng    <= n_groups;
            cfg_shift <= shift;
            cfg_bias  <= bias_en;
            cfg_act   <= act_mode;
            cfg_sat   <= sat_en;
            cfg_mp    <= mp_len;
            smp_cnt   <= '0;
            grp_cnt   <= '0;
            // Empty runs finish immediately without touching the datapath
            if (acc_len == '0 || n_groups == '0) begin
              done <= 1'b1;
            end else begin
              state    <= ST_RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (smp_last) begin
              smp_cnt <= '0;
              grp_cnt <= grp_cnt + LEN_W'(1);
              if (grp_last) begin
                state     <= ST_DRAIN;
                in_ready  <= 1'b0;
                drain_cnt <= '0;
              end
            end else begin
              smp_cnt <= smp_cnt + LEN_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'(DRAIN_CYCLES-1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  logic                     v1, first1, last1, fin1;
  logic signed [DATA_W-1:0] a1, b1, c1;
  logic                     v2, first2, last2, fin2;
  logic signed [ACC_W-1:0]  prod2;
  logic signed [DATA_W-1:0] c2;
  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [ACC_W-1:0]  bias_sh, acc_base, acc;
  logic                     grp_v3, fin3;

  assign prod_full = a1 * b1;
  assign bias_sh   = ACC_W'(c2) <<< cfg_shift;
  // A group's first product replaces the running sum, so back-to-back groups need no bubble
  assign acc_base  = !first2 ? acc : (cfg_bias ? bias_sh : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; first1 <= 1'b0; last1 <= 1'b0; fin1 <= 1'b0;
      a1 <= '0; b1 <= '0; c1 <= '0;
      v2 <= 1'b0; first2 <= 1'b0; last2 <= 1'b0; fin2 <= 1'b0;
      prod2 <= '0; c2 <= '0;
      grp_v3 <= 1'b0; fin3 <= 1'b0; acc <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1     <= op_a;
        b1     <= op_b;
        c1     <= op_c;
        first1 <= (smp_cnt == '0);
        last1  <= smp_last;
        fin1   <= smp_last & grp_last;
      end
      v2 <= v1;
      if (v1) begin
        prod2  <= ACC_W'(prod_full);
        c2     <= c1;
        first2 <= first1;
        last2  <= last1;
        fin2   <= fin1;
      end
      grp_v3 <= v2 & last2;
      fin3   <= v2 & fin2;
      if (v2) acc <= acc_base + prod2;
    end
  end

  logic                    pp_valid, pp_last;
  logic signed [OUT_W-1:0] pp_data;

  xyolo_postproc #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .SHIFT_W  (SHIFT_W),
    .LEAKY_SH (LEAKY_SH)
  ) u_postproc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (grp_v3),
    .in_last   (fin3),
    .acc       (acc),
    .shift     (cfg_shift),
    .act_mode  (cfg_act),
    .sat_en    (cfg_sat),
    .out_valid (pp_valid),
    .out_last  (pp_last),
    .out_data  (pp_data)
  );

  logic [MP_W-1:0]         pool_cnt, mp_last_idx;
  logic signed [OUT_W-1:0] pool_max, pool_cur;

  assign mp_last_idx = (cfg_mp == '0) ? '0 : cfg_mp - MP_W'(1);
  assign pool_cur    = (pool_cnt == '0 || pp_data > pool_max) ? pp_data : pool_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_cnt  <= '0;
      pool_max  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (pp_valid) begin
        // The run's final result closes the window even when it is partial
        if (pool_cnt == mp_last_idx || pp_last) begin
          out_valid <= 1'b1;
          out_data  <= pool_cur;
          pool_cnt  <= '0;
        end else begin
          pool_max <= pool_cur;
          pool_cnt <= pool_cnt + MP_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xyolo_macc_pool.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_xyolo_macc_pool : directed + randomized bench with reference model|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_xyolo_macc_pool;

  localparam int DATA_W = 16, ACC_W = 40, OUT_W = 16, LEN_W = 12;
  localparam int SHIFT_W = 5, MP_W = 3, LEAKY_SH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [LEN_W-1:0] acc_len = '0, n_groups = '0;
  logic [SHIFT_W-1:0] shift = '0;
  logic bias_en = 1'b0, sat_en = 1'b0, in_valid = 1'b0;
  logic [1:0] act_mode = '0;
  logic [MP_W-1:0] mp_len = '0;
  logic signed [DATA_W-1:0] op_a = '0, op_b = '0, op_c = '0;
  logic in_ready, out_valid, busy, done;
  logic signed [OUT_W-1:0] out_data;

  xyolo_macc_pool #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W),
    .SHIFT_W(SHIFT_W), .MP_W(MP_W), .LEAKY_SH(LEAKY_SH)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .acc_len(acc_len), .n_groups(n_groups),
    .shift(shift), .bias_en(bias_en), .act_mode(act_mode), .sat_en(sat_en),
    .mp_len(mp_len), .in_valid(in_valid), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  int sa[$], sb[$], sc[$];
  longint exp_q[$];
  logic signed [OUT_W-1:0] got_q[$];
  int gcyc_q[$], done_q[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_q.push_back(out_data);
      gcyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] got_at(input int i);
    logic signed [63:0] g;
    g = 'x;
    if (i < got_q.size()) g = got_q[i];
    return g;
  endfunction

  // Reference: per-group dot product plus bias, then shift/activation/clamp, then windowed max
  task automatic build_expected(input int len, ng, sh, be, act, sat, mp);
    longint acc, s, r, best;
    logic signed [ACC_W-1:0] wrap;
    logic signed [OUT_W-1:0] lo;
    int mpe, inwin;
    exp_q.delete();
    mpe = (mp == 0) ? 1 : mp;
    inwin = 0;
    best = 0;
    for (int g = 0; g < ng; g++) begin
      acc = (be != 0) ? (longint'(sc[g*len]) <<< sh) : 64'sd0;
      for (int k = 0; k < len; k++)
        acc += longint'(sa[g*len+k]) * longint'(sb[g*len+k]);
      wrap = acc[ACC_W-1:0];
      acc = wrap;
      s = acc >>> sh;
      if (act == 1 && s < 0) s = 0;
      else if (act == 2 && s < 0) s = s >>> LEAKY_SH;
      if (sat != 0) r = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
      else begin lo = s[OUT_W-1:0]; r = lo; end
      if (inwin == 0 || r > best) best = r;
      inwin++;
      if (inwin == mpe || g == ng-1) begin
        exp_q.push_back(best);
        inwin = 0;
      end
    end
  endtask

  task automatic fill_random(input int n);
    sa.delete(); sb.delete(); sc.delete();
    for (int i = 0; i < n; i++) begin
      sa.push_back(int'($urandom_range(65535)) - 32768);
      sb.push_back(int'($urandom_range(65535)) - 32768);
      sc.push_back(int'($urandom_range(65535)) - 32768);
    end
  endtask

  task automatic run_case(input string tag, input int len, ng, sh, be, act, sat, mp,
                          input int gap, input bit poke);
    int last_cyc, start_cyc, w;
    got_q.delete(); gcyc_q.delete(); done_q.delete();
    build_expected(len, ng, sh, be, act, sat, mp);
    last_cyc = 0;
    @(posedge clk); #1;
    acc_len = LEN_W'(len); n_groups = LEN_W'(ng); shift = SHIFT_W'(sh);
    bias_en = be[0]; act_mode = act[1:0]; sat_en = sat[0]; mp_len = MP_W'(mp);
    run = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    run = 1'b0;
    acc_len = LEN_W'($urandom); n_groups = LEN_W'($urandom); shift = SHIFT_W'($urandom);
    act_mode = 2'($urandom); mp_len = MP_W'($urandom); sat_en = 1'($urandom);
    if (len == 0 || ng == 0) begin
      in_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1 in_valid = 1'b0;
      check({tag, " outs"}, got_q.size(), 0);
      check({tag, " done count"}, done_q.size(), 1);
      if (done_q.size() > 0) check({tag, " done cycle"}, done_q[0], start_cyc);
      check({tag, " busy"}, busy, 1'b0);
      return;
    end
    for (int i = 0; i < len*ng; i++) begin
      while ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      op_a = 16'(sa[i]); op_b = 16'(sb[i]); op_c = 16'(sc[i]);
      if (poke && i == 1) begin
        run = 1'b1; acc_len = 12'd1; n_groups = 12'd1; mp_len = 3'd1; shift = 5'd0;
      end
      check({tag, " in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      last_cyc = cyc;
      run = 1'b0;
    end
    in_valid = 1'b0;
    w = 0;
    while (done_q.size() == 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, " out count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check({tag, " data"}, got_at(i), exp_q[i]);
    if (gcyc_q.size() > 0) check({tag, " latency"}, gcyc_q[gcyc_q.size()-1], last_cyc + 4);
    check({tag, " done count"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, " done cycle"}, done_q[0], last_cyc + 4);
    check({tag, " busy after"}, busy, 1'b0);
  endtask

  initial begin
    #100000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst out_data", out_data, 0);
    check("rst out_valid", out_valid, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst in_ready", in_ready, 0);
    rst = 1'b0;

    sa = '{1, 2, 3}; sb = '{4, 5, 6}; sc = '{5, 0, 0};
    run_case("bias", 3, 1, 2, 1, 0, 0, 1, 0, 0);
    check("bias value", got_at(0), 13);

    sa = '{-64}; sb = '{1}; sc = '{0};
    run_case("relu", 1, 1, 0, 0, 1, 0, 1, 0, 0);
    check("relu value", got_at(0), 0);
    run_case("leaky", 1, 1, 0, 0, 2, 0, 1, 0, 0);
    check("leaky value", got_at(0), -8);
    run_case("none", 1, 1, 0, 0, 0, 0, 1, 0, 0);
    check("none value", got_at(0), -64);

    sa = '{32767, 32767, 32767, 32767}; sb = sa; sc = '{0, 0, 0, 0};
    run_case("sat", 4, 1, 0, 0, 0, 1, 1, 0, 0);
    check("sat value", got_at(0), 32767);
    run_case("trunc", 4, 1, 0, 0, 0, 0, 1, 0, 0);
    check("trunc value", got_at(0), 4);

    sa = '{3, -7, 9, 2, -1}; sb = '{1, 1, 1, 1, 1}; sc = '{0, 0, 0, 0, 0};
    run_case("pool", 1, 5, 0, 0, 0, 0, 2, 0, 0);
    check("pool w0", got_at(0), 3);
    check("pool w1", got_at(1), 9);
    check("pool flush", got_at(2), -1);

    for (int it = 0; it < 4; it++) begin
      int ng, sh, be, act, sat, mp;
      ng = int'($urandom_range(1, 6)); sh = int'($urandom_range(0, 12));
      be = int'($urandom_range(0, 1)); act = int'($urandom_range(0, 3));
      sat = int'($urandom_range(0, 1)); mp = int'($urandom_range(0, 7));
      fill_random(8 * ng);
      run_case("rand nogap", 8, ng, sh, be, act, sat, mp, 0, 0);
      run_case("rand gap", 8, ng, sh, be, act, sat, mp, 50, (it == 1));
    end

    run_case("len0", 0, 3, 0, 0, 0, 0, 1, 0, 0);
    run_case("ng0", 4, 0, 0, 0, 0, 0, 1, 0, 0);

    sa = '{1, 2, 3}; sb = '{4, 5, 6}; sc = '{5, 0, 0};
    run_case("pre-rst", 3, 1, 2, 1, 0, 0, 1, 0, 0);
    fill_random(16);
    @(posedge clk); #1;
    acc_len = 12'd8; n_groups = 12'd2; shift = 5'd0; bias_en = 1'b1;
    act_mode = 2'd0; sat_en = 1'b0; mp_len = 3'd1; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_a = 16'(sa[i]); op_b = 16'(sb[i]); op_c = 16'(sc[i]);
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("arst out_data", out_data, 0);
    check("arst out_valid", out_valid, 0);
    check("arst busy", busy, 0);
    check("arst in_ready", in_ready, 0);
    check("arst done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    got_q.delete(); done_q.delete();
    repeat (8) @(posedge clk);
    #1;
    check("arst no outs", got_q.size(), 0);
    check("arst no done", done_q.size(), 0);
    fill_random(8 * 3);
    run_case("post-rst", 8, 3, 3, 1, 2, 1, 2, 20, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
